// File: rtl/c1541_pkg.sv
// rtl/c1541_pkg.sv - shared types and constants for the c1541 SD arbiter
package c1541_pkg;

  localparam int LBA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DONE
  } state_t;

  // Successor of index i in a ring of n entries.
  function automatic int unsigned ring_next(int unsigned i, int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/c1541_rr_pick.sv
// rtl/c1541_rr_pick.sv - combinational round-robin picker starting at ptr
module c1541_rr_pick
  import c1541_pkg::*;
#(
  parameter int NDRIVES = 4,
  parameter int IDXW    = 2
) (
  input  logic [NDRIVES-1:0] pending,
  input  logic [IDXW-1:0]    ptr,
  output logic               hit,
  output logic [IDXW-1:0]    idx
);

  int unsigned cand;

  // Walk the ring from ptr and take the first pending drive.
  always_comb begin
    cand = 32'(ptr);
    hit  = 1'b0;
    idx  = '0;
    for (int k = 0; k < NDRIVES; k++) begin
      if (!hit && cand < 32'(NDRIVES) && pending[cand[IDXW-1:0]]) begin
        hit = 1'b1;
        idx = cand[IDXW-1:0];
      end
      cand = ring_next(cand, 32'(NDRIVES));
    end
  end

endmodule

// File: rtl/c1541_sd_arbiter.sv
// rtl/c1541_sd_arbiter.sv - round-robin sharing of one host SD block port among drives
module c1541_sd_arbiter
  import c1541_pkg::*;
#(
  parameter int NDRIVES = 4,
  parameter int IDXW    = 2
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [LBA_W*NDRIVES-1:0] drv_lba,
  input  logic [NDRIVES-1:0]       drv_rd,
  input  logic [NDRIVES-1:0]       drv_wr,
  output logic [NDRIVES-1:0]       drv_ack,
  input  logic [8*NDRIVES-1:0]     drv_buff_din,
  output logic [NDRIVES-1:0]       drv_buff_wr,
  output logic [LBA_W-1:0]         sd_lba,
  output logic                     sd_rd,
  output logic                     sd_wr,
  input  logic                     sd_ack,
  output logic [7:0]               sd_buff_din,
  input  logic                     sd_buff_wr,
  output logic [NDRIVES-1:0]       grant
);

  localparam logic [NDRIVES-1:0] GRANT_LSB = {{(NDRIVES-1){1'b0}}, 1'b1};

  state_t            state;
  state_t            state_nx;
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_hit;
  logic              op_wr;
  logic              req_held;
  logic [NDRIVES-1:0] pending;
  logic [LBA_W-1:0]  lba_arr [NDRIVES];
  logic [7:0]        din_arr [NDRIVES];

  assign pending  = drv_rd | drv_wr;
  assign req_held = pending[idx];

  // Unpack the per-drive LBA and write-data buses into arrays.
  always_comb begin
    for (int i = 0; i < NDRIVES; i++) begin
      lba_arr[i] = drv_lba[LBA_W*i +: LBA_W];
      din_arr[i] = drv_buff_din[8*i +: 8];
    end
  end

  c1541_rr_pick #(
    .NDRIVES (NDRIVES),
    .IDXW    (IDXW)
  ) u_pick (
    .pending (pending),
    .ptr     (ptr),
    .hit     (pick_hit),
    .idx     (pick_idx)
  );

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state: ack takes priority over a withdrawn request in REQ.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pick_hit) state_nx = ST_REQ;
      ST_REQ: begin
        if (sd_ack)         state_nx = ST_XFER;
        else if (!req_held) state_nx = ST_IDLE;
      end
      ST_XFER: if (!sd_ack) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Grant, latched request and host-side request lines.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      idx    <= '0;
      op_wr  <= 1'b0;
      sd_lba <= '0;
      sd_rd  <= 1'b0;
      sd_wr  <= 1'b0;
      grant  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_hit) begin
            idx    <= pick_idx;
            sd_lba <= lba_arr[pick_idx];
            op_wr  <= drv_wr[pick_idx];
            grant  <= GRANT_LSB << pick_idx;
          end
        end
        ST_REQ: begin
          if (sd_ack || !req_held) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            if (!sd_ack) grant <= '0;
          end else begin
            sd_rd <= !op_wr;
            sd_wr <= op_wr;
          end
        end
        ST_XFER: begin
          if (!sd_ack) grant <= '0;
        end
        ST_DONE: begin
          ptr <= IDXW'(ring_next(32'(idx), 32'(NDRIVES)));
        end
        default: ;
      endcase
    end
  end

  // Route host ack/strobe to the owner only; byte strobes count only in XFER.
  always_comb begin
    drv_ack     = sd_ack ? grant : '0;
    drv_buff_wr = (sd_buff_wr && state == ST_XFER) ? grant : '0;
    sd_buff_din = (grant != '0) ? din_arr[idx] : 8'h00;
  end

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// tb/tb_c1541_sd_arbiter.sv - scoreboard bench for c1541_sd_arbiter
module tb_c1541_sd_arbiter;

  localparam int ND = 4;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic [32*ND-1:0] drv_lba;
  logic [ND-1:0]   drv_rd;
  logic [ND-1:0]   drv_wr;
  logic [ND-1:0]   drv_ack;
  logic [8*ND-1:0] drv_buff_din;
  logic [ND-1:0]   drv_buff_wr;
  logic [31:0]     sd_lba;
  logic            sd_rd;
  logic            sd_wr;
  logic            sd_ack;
  logic [7:0]      sd_buff_din;
  logic            sd_buff_wr;
  logic [ND-1:0]   grant;

  c1541_sd_arbiter #(.NDRIVES(ND), .IDXW(2)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_lba      (drv_lba),
    .drv_rd       (drv_rd),
    .drv_wr       (drv_wr),
    .drv_ack      (drv_ack),
    .drv_buff_din (drv_buff_din),
    .drv_buff_wr  (drv_buff_wr),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_din  (sd_buff_din),
    .sd_buff_wr   (sd_buff_wr),
    .grant        (grant)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          idx;
    logic [31:0] lba;
    bit          wr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: set of pending drives, their requests, and the rotation start.
  bit [ND-1:0] m_pend = '0;
  logic [31:0] m_lba [ND];
  bit          m_wr  [ND];
  int          m_ptr = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic raise(int d, bit rd, bit wr, logic [31:0] lba);
    drv_lba[32*d +: 32] = lba;
    drv_rd[d] = rd;
    drv_wr[d] = wr;
    m_pend[d] = 1'b1;
    m_lba[d]  = lba;
    m_wr[d]   = wr;
  endtask

  task automatic raise_rand(int d);
    int op;
    op = $urandom_range(0, 2);
    raise(d, op != 1, op != 0, $urandom);
  endtask

  // Next owner: first pending drive found scanning forward from the rotation start.
  function automatic int rr_next();
    for (int k = 0; k < ND; k++)
      if (m_pend[(m_ptr + k) % ND]) return (m_ptr + k) % ND;
    return -1;
  endfunction

  task automatic expect_next(output int d);
    exp_t e;
    d = rr_next();
    e.idx = d;
    e.lba = m_lba[d];
    e.wr  = m_wr[d];
    sb.push_back(e);
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!(sd_rd || sd_wr) && n < 20) begin
      step();
      n++;
    end
    ok = sd_rd || sd_wr;
    check("req_seen", 64'(ok), 64'd1);
  endtask

  // Host side of one block transfer for drive d, then the drive releases its request.
  task automatic serve(int d, int len);
    bit ok;
    wait_req(ok);
    if (ok) begin
      drv_lba[32*d +: 32] = $urandom;
      repeat ($urandom_range(0, 2)) step();
      sd_ack = 1'b1;
      step();
      for (int i = 0; i < len; i++) begin
        sd_buff_wr   = 1'($urandom_range(0, 1));
        drv_buff_din = $urandom;
        step();
      end
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
    end
    drv_rd[d] = 1'b0;
    drv_wr[d] = 1'b0;
    m_pend[d] = 1'b0;
    m_ptr     = (d + 1) % ND;
  endtask

  task automatic run_pending(int max_len, bit churn);
    int d;
    int guard;
    guard = 0;
    while (m_pend != '0 && guard < 64) begin
      expect_next(d);
      serve(d, $urandom_range(2, max_len));
      if (churn && $urandom_range(0, 2) == 0) raise_rand(d);
      if (churn)
        for (int i = 0; i < ND; i++)
          if (!m_pend[i] && i != d && $urandom_range(0, 3) == 0) raise_rand(i);
      guard++;
    end
  endtask

  // Monitor: pop an expectation on each new host request; check routing during the transfer.
  exp_t cur;
  bit   cur_valid = 1'b0;
  bit   req_prev  = 1'b0;
  always @(negedge clk_sys) begin
    if (reset) begin
      cur_valid = 1'b0;
      req_prev  = 1'b0;
    end else begin
      if ((sd_rd || sd_wr) && !req_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_request", 64'd1, 64'd0);
        end else begin
          cur = sb.pop_front();
          cur_valid = 1'b1;
          check("grant", 64'(grant), 64'(1 << cur.idx));
          check("sd_lba", 64'(sd_lba), 64'(cur.lba));
          check("sd_wr", 64'(sd_wr), 64'(cur.wr));
          check("sd_rd", 64'(sd_rd), 64'(!cur.wr));
        end
      end
      if (cur_valid && sd_ack) begin
        check("drv_ack", 64'(drv_ack), 64'(1 << cur.idx));
        if (sd_buff_wr) begin
          check("drv_buff_wr", 64'(drv_buff_wr), 64'(1 << cur.idx));
          check("sd_buff_din", 64'(sd_buff_din), 64'(drv_buff_din[8*cur.idx +: 8]));
          check("sd_lba_held", 64'(sd_lba), 64'(cur.lba));
        end
      end
      req_prev = sd_rd || sd_wr;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bit ok;
    reset        = 1'b1;
    drv_lba      = '0;
    drv_rd       = '0;
    drv_wr       = '0;
    drv_buff_din = '0;
    sd_ack       = 1'b0;
    sd_buff_wr   = 1'b0;
    step();
    step();
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_sd_rd_wr", 64'({sd_rd, sd_wr}), 64'd0);
    check("rst_sd_lba", 64'(sd_lba), 64'd0);
    check("rst_drv_ack", 64'(drv_ack), 64'd0);
    reset = 1'b0;
    step();

    // Stray host ack and byte strobe while idle.
    sd_ack = 1'b1;
    sd_buff_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_ack_drv_ack", 64'(drv_ack), 64'd0);
      check("idle_ack_grant", 64'(grant), 64'd0);
      check("idle_buff_wr", 64'(drv_buff_wr), 64'd0);
    end
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    step();
    check("idle_sd_rd_wr", 64'({sd_rd, sd_wr}), 64'd0);

    // Single read from drive 2 with a long transfer.
    raise(2, 1'b1, 1'b0, 32'h1A3);
    expect_next(d);
    step();
    step();
    check("t1_sd_rd", 64'(sd_rd), 64'd1);
    check("t1_grant", 64'(grant), 64'b0100);
    check("t1_sd_lba", 64'(sd_lba), 64'h1A3);
    serve(d, 510);

    // All four reading at once: rotation continues after drive 2.
    for (int i = 0; i < ND; i++) raise(i, 1'b1, 1'b0, $urandom);
    run_pending(6, 1'b0);

    // Read and write together: write wins.
    raise(1, 1'b1, 1'b1, 32'hCAFE_0001);
    run_pending(8, 1'b0);

    // Randomized traffic with immediate re-requests.
    for (int r = 0; r < 3; r++) begin
      int mask;
      mask = $urandom_range(1, (1 << ND) - 1);
      for (int i = 0; i < ND; i++) if (mask[i]) raise_rand(i);
      run_pending(12, 1'b1);
    end
    run_pending(6, 1'b0);

    // Withdrawal before ack: request aborts, rotation start unchanged.
    d = m_ptr;
    raise(d, 1'b1, 1'b0, $urandom);
    expect_next(d);
    wait_req(ok);
    sd_buff_wr = 1'b1;
    #1;
    check("req_buff_wr_dropped", 64'(drv_buff_wr), 64'd0);
    sd_buff_wr = 1'b0;
    drv_rd[d] = 1'b0;
    m_pend[d] = 1'b0;
    step();
    check("abort_sd_rd", 64'(sd_rd), 64'd0);
    check("abort_grant", 64'(grant), 64'd0);
    for (int i = 0; i < ND; i++) raise_rand(i);
    run_pending(5, 1'b0);

    // Reset in the middle of a drive 3 write.
    raise(3, 1'b0, 1'b1, $urandom);
    expect_next(d);
    wait_req(ok);
    sd_ack = 1'b1;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_grant", 64'(grant), 64'd0);
    check("mid_rst_sd_rd_wr", 64'({sd_rd, sd_wr}), 64'd0);
    check("mid_rst_sd_lba", 64'(sd_lba), 64'd0);
    check("mid_rst_drv_ack", 64'(drv_ack), 64'd0);
    check("mid_rst_buff", 64'({drv_buff_wr, sd_buff_din}), 64'd0);
    drv_wr[3] = 1'b0;
    m_pend    = '0;
    m_ptr     = 0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_drv_ack", 64'(drv_ack), 64'd0);
      check("post_rst_grant", 64'(grant), 64'd0);
    end
    sd_ack = 1'b0;
    step();

    // After reset the rotation starts again at drive 0.
    for (int i = 0; i < ND; i++) raise(i, 1'b1, 1'b0, $urandom);
    run_pending(4, 1'b0);

    repeat (4) step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
